uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ requesters.
// Define UART_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic                 uart_wr_o,
   output logic [7:0]           uart_dat_o,
   input  logic                 uart_busy_i,
   output logic                 idle_o
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(START_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;
   state_t             state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [IW-1:0]      win;
   logic               found;
   logic [NUM_REQ-1:0] ready_n, grant_n;
   logic [7:0]         dat_n;
`ifdef UART_ARB_RR_EN
   logic [IW-1:0]      last_grant, last_grant_n;
   int                 idx;
   // search begins one past the previous winner and wraps
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx[IW-1:0]]) begin
            found = 1'b1;
            win   = idx[IW-1:0];
         end
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) last_grant <= IW'(NUM_REQ - 1);
      else     last_grant <= last_grant_n;
`else
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req_valid[k]) begin
            found = 1'b1;
            win   = IW'(k);
         end
   end
`endif
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ready_n = '0;
      grant_n = grant_o;
      dat_n   = uart_dat_o;
`ifdef UART_ARB_RR_EN
      last_grant_n = last_grant;
`endif
      case (state)
         IDLE:
            if (found && !uart_busy_i) begin
               state_n = ISSUE;
               ready_n = NUM_REQ'(1) << win;
               grant_n = NUM_REQ'(1) << win;
               dat_n   = req_data[8*win +: 8];
`ifdef UART_ARB_RR_EN
               last_grant_n = win;
`endif
            end
         ISSUE: begin
            state_n = WAIT_START;
            cnt_n   = '0;
         end
         WAIT_START:
            if (uart_busy_i || cnt == CW'(START_TIMEOUT - 1)) state_n = WAIT_DONE;
            else cnt_n = cnt + 1'b1;
         WAIT_DONE:
            if (!uart_busy_i) begin
               state_n = IDLE;
               grant_n = '0;
            end
         default: state_n = IDLE;
      endcase
   end
   // outputs are registered; the write strobe follows the ISSUE cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= '0;
         grant_o    <= '0;
         uart_wr_o  <= 1'b0;
         uart_dat_o <= 8'h00;
         idle_o     <= 1'b1;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         req_ready  <= ready_n;
         grant_o    <= grant_n;
         uart_wr_o  <= state == ISSUE;
         uart_dat_o <= dat_n;
         idle_o     <= state_n == IDLE;
      end
endmodule
